// File: rtl/gate_unit_pipe.sv
// gate_unit_pipe: registered WIDTH-bit bitwise logic unit
// with valid/ready skid buffer, result flags and delivery counter.
module gate_unit_pipe #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [2:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_y,
  output logic               out_zero,
  output logic               out_parity,
  output logic [COUNT_W-1:0] txn_count
);

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             parity;
  } beat_t;

  localparam beat_t BEAT_RST = {{WIDTH{1'b0}}, 1'b1, 1'b0};

  beat_t              m_q;
  beat_t              s_q;
  beat_t              nxt;
  logic               m_valid;
  logic               s_valid;
  logic [COUNT_W-1:0] cnt_q;
  logic [WIDTH-1:0]   y_c;
  logic               accept;
  logic               deliver;

  always_comb begin
    y_c = '0;
    unique case (in_op)
      3'd0: y_c = ~(in_a & in_b);
      3'd1: y_c = in_a & in_b;
      3'd2: y_c = in_a | in_b;
      3'd3: y_c = ~(in_a | in_b);
      3'd4: y_c = in_a ^ in_b;
      3'd5: y_c = ~(in_a ^ in_b);
      3'd6: y_c = ~in_a;
      3'd7: y_c = in_a;
    endcase
  end

  always_comb begin
    nxt.y      = y_c;
    nxt.zero   = (y_c == '0);
    nxt.parity = ^y_c;
  end

  assign accept  = in_valid && !s_valid;
  assign deliver = m_valid && out_ready;

  // Beats are only written on accept, so idle-cycle X never lands in M/S.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_q     <= BEAT_RST;
      s_q     <= BEAT_RST;
      cnt_q   <= '0;
    end else begin
      if (deliver) begin
        cnt_q <= cnt_q + COUNT_W'(1);
      end
      if (deliver && s_valid) begin
        m_q     <= s_q;
        s_valid <= 1'b0;
      end else if (accept && (!m_valid || deliver)) begin
        m_q     <= nxt;
        m_valid <= 1'b1;
      end else if (accept) begin
        s_q     <= nxt;
        s_valid <= 1'b1;
      end else if (deliver) begin
        m_valid <= 1'b0;
      end
    end
  end

  assign in_ready   = !s_valid;
  assign out_valid  = m_valid;
  assign out_y      = m_q.y;
  assign out_zero   = m_q.zero;
  assign out_parity = m_q.parity;
  assign txn_count  = cnt_q;

endmodule

// File: tb/tb_gate_unit_pipe.sv
// tb_gate_unit_pipe: scoreboard bench for gate_unit_pipe,
// random stalls plus directed truth-table, backpressure and reset cases.
module tb_gate_unit_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [2:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_y;
  logic        out_zero;
  logic        out_parity;
  logic [15:0] txn_count;

  logic        s_in_ready;
  logic        s_out_valid;
  logic [7:0]  s_out_y;
  logic        s_out_zero;
  logic        s_out_parity;
  logic [1:0]  s_txn_count;

  typedef struct {
    logic [7:0] y;
    logic       zero;
    logic       parity;
  } exp_t;

  exp_t       q[$];
  logic [7:0] log_y[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         exp_cnt = 0;

  always #5 clk = ~clk;

  gate_unit_pipe #(.WIDTH(8), .COUNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_zero(out_zero),
    .out_parity(out_parity), .txn_count(txn_count)
  );

  gate_unit_pipe #(.WIDTH(8), .COUNT_W(2)) dut_small (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_y(s_out_y), .out_zero(s_out_zero),
    .out_parity(s_out_parity), .txn_count(s_txn_count)
  );

  function automatic exp_t ref_beat(logic [7:0] a, logic [7:0] b,
                                    logic [2:0] op);
    exp_t r;
    logic [7:0] y;
    case (op)
      3'd0: y = ~(a & b);
      3'd1: y = a & b;
      3'd2: y = a | b;
      3'd3: y = ~(a | b);
      3'd4: y = a ^ b;
      3'd5: y = ~(a ^ b);
      3'd6: y = ~a;
      default: y = a;
    endcase
    r.y      = y;
    r.zero   = (y == 8'h00);
    r.parity = ($countones(y) % 2) == 1;
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard push: a beat is accepted at the next rising edge.
  always begin
    @(negedge clk);
    #1;
    if (!rst && in_valid && in_ready)
      q.push_back(ref_beat(in_a, in_b, in_op));
  end

  // Monitor: queue occupancy is the reference for valid/ready state.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      exp_cnt = 0;
    end else begin
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("small_hs", {s_in_ready, s_out_valid},
          {q.size() < 2, q.size() != 0});
      if (q.size() != 0) begin
        chk("out_y", 32'(out_y), 32'(q[0].y));
        chk("out_zero", 32'(out_zero), 32'(q[0].zero));
        chk("out_parity", 32'(out_parity), 32'(q[0].parity));
        chk("small_res", {s_out_y, s_out_zero, s_out_parity},
            {q[0].y, q[0].zero, q[0].parity});
      end
      if (out_valid && out_ready && q.size() != 0) begin
        chk("txn_count", 32'(txn_count), 32'(exp_cnt % 65536));
        chk("txn_wrap", 32'(s_txn_count), 32'(exp_cnt % 4));
        log_y.push_back(out_y);
        void'(q.pop_front());
        exp_cnt++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] op);
    int n = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_op = op;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: in_ready stuck 0 for %0d cycles", n);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_reset_state();
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_y", 32'(out_y), 0);
    chk("rst_out_zero", 32'(out_zero), 1);
    chk("rst_out_parity", 32'(out_parity), 0);
    chk("rst_txn_count", 32'(txn_count), 0);
    tick();
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    in_valid = 1'b0;
    while ((out_valid || q.size() != 0) && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: out_valid=%0b queued=%0d",
               out_valid, q.size());
    end
  endtask

  logic [7:0] tt_exp[8] = '{8'hEE, 8'h11, 8'h77, 8'h88,
                            8'h66, 8'h99, 8'hCC, 8'h33};

  initial begin
    exp_t ea;
    exp_t eb;
    exp_t ec;
    int   sent;
    logic acc;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_op = '0;
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    reset_dut();
    check_reset_state();

    // Truth table, back-to-back with the sink always ready.
    out_ready = 1'b1;
    log_y.delete();
    for (int i = 0; i < 8; i++) send(8'h33, 8'h55, 3'(i));
    tick();
    tick();
    chk("tt_count", 32'(log_y.size()), 8);
    for (int i = 0; i < 8 && i < log_y.size(); i++)
      chk($sformatf("tt_op%0d", i), 32'(log_y[i]), 32'(tt_exp[i]));
    chk("tt_txn", 32'(txn_count), 8);

    // Flag corner cases.
    send(8'hF0, 8'h0F, 3'd1);
    send(8'h07, 8'hA5, 3'd7);
    drain();

    // Backpressure through the skid buffer.
    ea = ref_beat(8'h3C, 8'h5A, 3'd0);
    eb = ref_beat(8'h81, 8'h42, 3'd4);
    ec = ref_beat(8'hFF, 8'h00, 3'd3);
    out_ready = 1'b0;
    send(8'h3C, 8'h5A, 3'd0);
    chk("bp_ready_after_1", 32'(in_ready), 1);
    send(8'h81, 8'h42, 3'd4);
    chk("bp_ready_after_2", 32'(in_ready), 0);
    in_valid = 1'b1;
    in_a = 8'hFF;
    in_b = 8'h00;
    in_op = 3'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_ready", 32'(in_ready), 0);
      chk("bp_hold_y", 32'(out_y), 32'(ea.y));
    end
    out_ready = 1'b1;
    tick();
    chk("bp_y_b", 32'(out_y), 32'(eb.y));
    chk("bp_ready_back", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    chk("bp_y_c", 32'(out_y), 32'(ec.y));
    chk("bp_valid_c", 32'(out_valid), 1);
    tick();
    chk("bp_empty", 32'(out_valid), 0);

    // Reset with both registers full.
    out_ready = 1'b0;
    send(8'h12, 8'h34, 3'd2);
    send(8'h56, 8'h78, 3'd5);
    chk("mid_full", 32'(in_ready), 0);
    reset_dut();
    check_reset_state();
    log_y.delete();
    out_ready = 1'b1;
    send(8'hC3, 8'h0F, 3'd4);
    tick();
    ea = ref_beat(8'hC3, 8'h0F, 3'd4);
    chk("post_rst_n", 32'(log_y.size()), 1);
    if (log_y.size() != 0)
      chk("post_rst_y", 32'(log_y[0]), 32'(ea.y));
    drain();

    // Random traffic with random stalls on both sides.
    reset_dut();
    sent = 0;
    while (sent < 1000) begin
      if (!in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_a = 8'($urandom);
        in_b = 8'($urandom);
        in_op = 3'($urandom);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    drain();
    tick();
    chk("rand_txn", 32'(txn_count), 1000);
    chk("rand_txn_wrap", 32'(s_txn_count), 1000 % 4);
    chk("rand_delivered", 32'(exp_cnt), 1000);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gate_unit_pipe.md
Name: gate_unit_pipe

Overview:
- Parametrised, registered successor to the single 2-input NAND gate: WIDTH-bit bitwise logic unit with run-time op select (NAND plus seven other functions).
- Inputs and results move under a valid/ready handshake, with a 2-entry skid buffer so in_ready is driven from a register.
- Per-result zero/parity flags and a completed-transaction counter.
- Sits between a stimulus source and a result sink as the standard reusable gate block for later lessons.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1)
- COUNT_W, 16, width of transaction counter (>=1)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  unit can accept a beat; registered
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_op  input  3  function select, sampled with the beat
- out_valid  output  1  result valid
- out_ready  input  1  sink accepts result
- out_y  output  WIDTH  result
- out_zero  output  1  out_y == 0
- out_parity  output  1  XOR-reduce of out_y
- txn_count  output  COUNT_W  number of completed output handshakes, wraps

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high. All state changes on the rising edge of clk.
- Op encoding, bitwise on in_a/in_b:
  - 0 NAND, 1 AND, 2 OR, 3 NOR, 4 XOR, 5 XNOR
  - 6 NOT A (in_b ignored), 7 PASS A
- Result computation: y, zero and parity are computed combinationally from the input beat and stored with it. No arithmetic, no width growth.
- Handshakes:
  - Accept: in_valid && in_ready.
  - Deliver: out_valid && out_ready.
  - out_y/out_zero/out_parity hold stable while out_valid && !out_ready.
- Storage: main register M (drives outputs) and skid register S.
- in_ready = !S_valid (registered state, no combinational path from out_ready).
- On accept:
  - if !M_valid or deliver this cycle and !S_valid → beat written to M;
  - else → beat written to S.
- On deliver with S_valid: S moves to M, S_valid clears. A simultaneous accept is impossible because in_ready=0 when S_valid.
- On deliver with !S_valid and no accept: M_valid clears.
- Latency: 1 cycle from accept to out_valid when M empty or draining. Sustained throughput is 1 beat/cycle with out_ready held high.
- Ordering: strict FIFO; no beat dropped or duplicated.
- txn_count increments by 1 on each deliver; wraps 2^COUNT_W-1 → 0.
- Reset values: M_valid=0, S_valid=0, out_valid=0, in_ready=1, out_y=0, out_zero=1, out_parity=0, txn_count=0.
- Reset mid-operation discards all held beats; reset dominates a same-cycle accept or deliver.
- X on in_a/in_b/in_op while in_valid=0 must not propagate to outputs.

Test Plan:
- Truth table: WIDTH=8, out_ready=1, in_a=8'b0011_0011, in_b=8'b0101_0101, ops 0..7 on consecutive cycles. Outputs one cycle later, in order: 8'hEE, 8'h11, 8'h77, 8'h88, 8'h66, 8'h99, 8'hCC, 8'h33. Flags match; txn_count reaches 8.
- Flags: op1 with a=8'hF0, b=8'h0F → out_y=0, out_zero=1, out_parity=0. Op7 with a=8'h07 → out_zero=0, out_parity=1.
- Backpressure: out_ready=0 while sending 3 beats (A, B, C) back-to-back. in_ready drops after the 2nd accept; C is held by the source; out_y stays A. Raise out_ready: A, B, C are delivered on consecutive cycles; in_ready returns to 1 the cycle after S drains.
- Random stall: 1000 random beats with random in_valid/out_ready. A scoreboard confirms in-order, lossless results. txn_count = 1000 mod 2^COUNT_W.
- Wrap: COUNT_W=2 with 5 deliveries → txn_count sequence 1, 2, 3, 0, 1.
- Reset mid-flight: M and S full, assert rst for 1 cycle → next cycle out_valid=0, in_ready=1, txn_count=0, out_y=0. A new beat then passes normally.
